// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO-to-stream read adapter.
// Holds the skid buffer depth and the occupancy counter width.
package fifo_rd_stream_pkg;

   localparam int BUF_DEPTH = 2;
   localparam int CNT_W     = 2;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer with 1-bit wrapping pointers.
// Ports: clk, rst_n, clear, push/data_in, pop/data_out, count.
// data_out is the oldest entry, read straight from storage flops.
module stream_skid_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output cnt_t                  count
);

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   cnt_t                  cnt_q, cnt_d;
   logic                  do_push, do_pop;

   always_comb begin
      do_pop   = pop & (cnt_q != '0);
      // a full buffer only accepts a word when one leaves this cycle
      do_push  = push & ((cnt_q != cnt_t'(BUF_DEPTH)) | do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + cnt_t'(1);
         2'b01:   cnt_d = cnt_q - cnt_t'(1);
         default: cnt_d = cnt_q;
      endcase
      if (clear) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign data_out = mem_q[rd_ptr_q];
   assign count    = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO into a valid/ready stream through a 2-entry skid buffer.
// Ports: clk, rst_n (async, low), fifo_empty/fifo_rd_en/fifo_dout (FIFO side),
// flush, m_data/m_valid/m_ready (stream side), buf_cnt (buffer occupancy).
// Macro FIFO_RD_STREAM_FWFT_EN: drained FIFO is first-word-fall-through.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [1:0]            buf_cnt
);

   logic pop;
   logic push;
   logic inflight;
   cnt_t occ;

   assign m_valid = (buf_cnt != '0);
   assign pop     = m_valid & m_ready;

`ifdef FIFO_RD_STREAM_FWFT_EN
   // data is already on fifo_dout, so it lands at the popping edge
   assign inflight = 1'b0;
   assign push     = fifo_rd_en;
`else
   logic inflight_q, inflight_d;

   // fifo_rd_en is already low during flush, so nothing stays in flight
   always_comb begin
      inflight_d = fifo_rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   assign inflight = inflight_q;
   // a word returning during flush is dropped
   assign push     = inflight_q & ~flush;
`endif

   // issue only while buffer plus in-flight stays within the 2 entries
   always_comb begin
      occ        = buf_cnt + cnt_t'(inflight);
      fifo_rd_en = rst_n & ~fifo_empty & ~flush &
                   ((occ <= cnt_t'(1)) |
                    ((occ == cnt_t'(BUF_DEPTH)) & pop));
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .push     (push),
      .data_in  (fifo_dout),
      .pop      (pop),
      .data_out (m_data),
      .count    (buf_cnt)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized and directed bench for fifo_rd_stream.
// Scoreboard model tracks issued words with their issue cycle.
module tb_fifo_rd_stream;

`ifdef FIFO_RD_STREAM_FWFT_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_dout;
   logic       flush;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [1:0] buf_cnt;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .flush      (flush),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .buf_cnt    (buf_cnt)
   );

   // source FIFO
   logic [7:0] src_mem [4096];
   int         src_rd = 0;
   int         src_wr = 0;
   logic       hold_empty;
   logic [7:0] dout_r = 8'h00;
   int         cyc = 0;

   assign fifo_empty = hold_empty || (src_rd == src_wr);
`ifdef FIFO_RD_STREAM_FWFT_EN
   assign fifo_dout = src_mem[src_rd];
`else
   assign fifo_dout = dout_r;
`endif

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en && !fifo_empty) begin
         dout_r <= src_mem[src_rd];
         src_rd <= src_rd + 1;
      end
   end

   // scoreboard
   typedef struct {
      logic [7:0] d;
      int         c;
   } ent_t;

   ent_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   rd_cnt = 0;
   int   pop_cnt = 0;
   logic pv = 0, pr = 0, pf = 0, prst = 0;
   logic [7:0] pd = 0;

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      int  cap;
      logic ev, ep, erd;
      if (!rst_n) exp_q.delete();
      cap = 0;
      foreach (exp_q[i]) if (exp_q[i].c <= cyc - LAT) cap++;
      ev  = (cap != 0);
      ep  = ev && m_ready;
      erd = rst_n && !fifo_empty && !flush &&
            (exp_q.size() <= 1 || (exp_q.size() == 2 && ep));
      chk("buf_cnt", int'(buf_cnt), cap);
      chk("m_valid", int'(m_valid), int'(ev));
      if (ev) chk("m_data", int'(m_data), int'(exp_q[0].d));
      if (!rst_n) chk("m_data_rst", int'(m_data), 0);
      chk("fifo_rd_en", int'(fifo_rd_en), int'(erd));
      if (rst_n && prst && pv && !pr && !pf) begin
         chk("hold_valid", int'(m_valid), 1);
         chk("hold_data", int'(m_data), int'(pd));
      end
      if (fifo_rd_en) rd_cnt++;
      if (ep) begin
         void'(exp_q.pop_front());
         pop_cnt++;
      end
      if (flush) exp_q.delete();
      if (rst_n && fifo_rd_en && !fifo_empty)
         exp_q.push_back('{d: src_mem[src_rd], c: cyc});
      pv = m_valid; pr = m_ready; pf = flush; pd = m_data; prst = rst_n;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] w);
      src_mem[src_wr] = w;
      src_wr++;
   endtask

   task automatic wait_valid(input string name, input int want);
      int w;
      w = 0;
      @(negedge clk);
      while (!m_valid && w < 12) begin
         @(negedge clk);
         w++;
      end
      if (!m_valid) chk({name, "_timeout"}, 0, 1);
      else chk(name, int'(m_data), want);
   endtask

   initial begin
      int r0, p0;
      rst_n = 0; flush = 0; m_ready = 0; hold_empty = 1;
      repeat (3) step();
      rst_n = 1;
      step();

      // four preloaded words, sink always ready; this is cycle 0
      for (int i = 0; i < 4; i++) put(8'(8'h11 + i));
      m_ready = 1;
      hold_empty = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("s1_rd_en", int'(fifo_rd_en), (k <= 3) ? 1 : 0);
         if (k >= LAT && k < LAT + 4) begin
            chk("s1_valid", int'(m_valid), 1);
            chk("s1_data", int'(m_data), 'h11 + k - LAT);
         end
      end
      step();
      repeat (3) step();

      // stalled sink, then restart with no gaps
      m_ready = 0;
      r0 = rd_cnt;
      for (int i = 0; i < 8; i++) put(8'(8'h40 + i));
      repeat (6) step();
      @(negedge clk);
      chk("s2_pops", rd_cnt - r0, 2);
      chk("s2_cnt", int'(buf_cnt), 2);
      chk("s2_data", int'(m_data), 'h40);
      step();
      m_ready = 1;
      p0 = pop_cnt;
      repeat (8) step();
      chk("s2_burst", pop_cnt - p0, 8);
      repeat (3) step();

      // toggling sink
      p0 = pop_cnt;
      for (int i = 0; i < 16; i++) put(8'($urandom));
      for (int i = 0; i < 48; i++) begin
         step();
         m_ready = ~m_ready;
      end
      chk("s3_count", pop_cnt - p0, 16);
      m_ready = 0;
      repeat (4) step();

      // flush with a word in flight and one buffered
      hold_empty = 1;
      put(8'h31); put(8'h32); put(8'h33);
      step();
      hold_empty = 0;
      step();
      hold_empty = 1;
      repeat (3) step();
      hold_empty = 0;
      step();
      hold_empty = 1;
      flush = 1;
      step();
      flush = 0;
      @(negedge clk);
      chk("s4_valid", int'(m_valid), 0);
      chk("s4_cnt", int'(buf_cnt), 0);
      step();
      hold_empty = 0;
      m_ready = 1;
      wait_valid("s4_next", 'h33);
      step();
      repeat (3) step();

      // reset mid-stream with a full buffer
      m_ready = 0;
      for (int i = 0; i < 6; i++) put(8'(8'h51 + i));
      repeat (5) step();
      @(negedge clk);
      chk("s5_cnt", int'(buf_cnt), 2);
      step();
      rst_n = 0;
      @(negedge clk);
      chk("s5_valid", int'(m_valid), 0);
      chk("s5_rd_en", int'(fifo_rd_en), 0);
      chk("s5_data", int'(m_data), 0);
      step();
      rst_n = 1;
      m_ready = 1;
      wait_valid("s5_head", 'h53);
      step();
      repeat (6) step();

      // random traffic with occasional flush
      for (int i = 0; i < 1500; i++) begin
         step();
         m_ready    = ($urandom_range(0, 3) != 0);
         hold_empty = ($urandom_range(0, 4) == 0);
         flush      = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 1) == 1) put(8'($urandom));
      end
      step();
      flush = 0; m_ready = 1; hold_empty = 0;
      repeat (20) step();
      chk("drained", src_wr - src_rd, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
